nibble_seq_add16: RTL
=====================

NIBBLE_SEQ_ADD16 -- requirements
Module: nibble_seq_add16

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have port start, input, 1 bit: request a new 16-bit operation; sampled only when the block accepts requests.
REQ-004 The block SHALL have ports a and b, input, 16 bits each: operands, sampled together with start.
REQ-005 The block SHALL have port cin, input, 1 bit: carry-in for an add; ignored for a subtract.
REQ-006 The block SHALL have port sub, input, 1 bit: 0 selects add (a+b+cin); 1 selects subtract (a+~b+1).
REQ-007 The block SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a valid new result.
REQ-009 The block SHALL have port sum, output, 16 bits: registered result.
REQ-010 The block SHALL have port cout, output, 1 bit: carry out of bit 15; for a subtract, 1 means no borrow.
REQ-011 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow of the result.

Function
REQ-012 The datapath SHALL be one internal 4-bit adder slice (A, B, carry-in -> F, carry-out), reused over four cycles from nibble [3:0] up to nibble [15:12].
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 In IDLE, with start=1 at edge N, the block SHALL latch a, b, sub and the effective carry-in (cin, or 1 when sub=1), set the nibble index to 0 and enter RUN.
REQ-015 When sub=1, the B operand SHALL be inverted bitwise at latch time.
REQ-016 In RUN, at each of edges N+1 to N+4, the block SHALL add nibble[idx] of the latched operands with the carry register, store F into the accumulator nibble[idx], store carry-out into the carry register, and increment idx.
REQ-017 At edge N+4 (idx=3), the block SHALL load sum from the completed accumulator, load cout from the final carry, load ovf, and enter DONE.
REQ-018 ovf SHALL equal 1 exactly when latched a[15] equals latched (possibly inverted) b[15] and result bit 15 differs from a[15].
REQ-019 busy SHALL be 1 in RUN only, that is, in the cycles after edges N to N+3.
REQ-020 done SHALL be 1 in DONE only, for exactly one cycle after edge N+4, so latency is 4 cycles from start to done.
REQ-021 From DONE, with start=0 the block SHALL return to IDLE; with start=1 it SHALL accept the new operation exactly as in IDLE (back-to-back operation, no idle bubble).
REQ-022 start SHALL be ignored while in RUN; operands applied then SHALL have no effect.
REQ-023 sum, cout and ovf SHALL change only at the RUN->DONE transition and hold their values until the next completion or reset.
REQ-024 All arithmetic SHALL be modulo 2^16; the carry out of bit 15 goes only to cout.

Reset
REQ-025 When rst=1 at a rising edge, the block SHALL enter IDLE and clear busy, done, sum, cout, ovf, the accumulator, the carry register and idx to 0.
REQ-026 rst SHALL take priority over start and over any in-progress operation; an aborted operation SHALL never produce a done pulse.
REQ-027 start asserted in the same cycle as rst SHALL be discarded.

Verification
REQ-028 A directed test SHALL cover: a=0x1234, b=0x4321, cin=0, sub=0, start at edge N -> busy=1 for 4 cycles, done=1 after edge N+4 only, sum=0x5555, cout=0, ovf=0.
REQ-029 A directed test SHALL cover: a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1, ovf=0; repeat with a=0x00FF, b=0x0000, cin=1 -> sum=0x0100, cout=0, ovf=0 (carry ripples across nibbles).
REQ-030 A directed test SHALL cover: a=0x7FFF, b=0x0001, cin=0, sub=0 -> sum=0x8000, cout=0, ovf=1.
REQ-031 A directed test SHALL cover: a=0x0005, b=0x0007, sub=1, cin=1 -> sum=0xFFFE, cout=0, ovf=0; then a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
REQ-032 A directed test SHALL cover: second start with a=0x1111, b=0x1111 pulsed at edge N+2 -> ignored, first result unchanged; start held high during the DONE cycle -> second result 0x2222 with done after 4 further edges.
REQ-033 A directed test SHALL cover: rst=1 at edge N+2 of an operation -> busy=0, done=0, sum=0x0000 from the next cycle, with no done pulse afterwards.

Source files
------------

// File: rtl/nibble_seq_add16_if.sv
// Handshake and operand/result bundle for the nibble-serial 16-bit adder.
// The master drives requests and operands; the slave returns status and results.
interface nibble_seq_add16_if;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/nibble_seq_add16.sv
// 16-bit add/subtract built from one 4-bit slice reused over four cycles; done 4 cycles after start.
// No backpressure: start is ignored while busy, and a new request is accepted in the done cycle.
module nibble_seq_add16 (
  input  logic               clk,
  input  logic               rst,
  nibble_seq_add16_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic        carry_q, carry_d;
  logic [15:0] acc_q, acc_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] sum_q, sum_d;
  logic        cout_q, cout_d;
  logic        ovf_q, ovf_d;

  logic [3:0]  a_nib;
  logic [3:0]  b_nib;
  logic [4:0]  slice;

  // The single shared 4-bit adder slice, steered by the nibble index.
  assign a_nib = a_q[{idx_q, 2'b00} +: 4];
  assign b_nib = b_q[{idx_q, 2'b00} +: 4];
  assign slice = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
          acc_d   = '0;
          idx_d   = 2'd0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        acc_d[{idx_q, 2'b00} +: 4] = slice[3:0];
        carry_d = slice[4];
        idx_d   = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          sum_d   = {slice[3:0], acc_q[11:0]};
          cout_d  = slice[4];
          ovf_d   = (a_q[15] == b_q[15]) && (slice[3] != a_q[15]);
          state_d = DONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      idx_q   <= 2'd0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule
